// File: rtl/sobel_mem_responder.sv
// Memory-side responder for the Sobel accelerator: splits 3x3 window reads into
// per-row word fetches and turns 16-bit result writes into byte-strobed word writes.
module sobel_mem_responder (
    input  logic        clk,
    input  logic        internal_rst_n,
    input  logic [15:0] img_width,
    input  logic        mem_read_req,
    input  logic [31:0] mem_read_addr,
    output logic        mem_read_ack,
    output logic [71:0] mem_read_data,
    input  logic        mem_write_req,
    input  logic [31:0] mem_write_addr,
    input  logic [15:0] mem_write_data,
    output logic        mem_write_ack,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        busy,
    output logic        err_misaligned
);

    typedef enum logic [2:0] {IDLE, RD_FETCH, RD_RESP, WR_BUS, WR_RESP} state_t;

    state_t      state;
    logic [31:0] row_addr;
    logic [31:0] stride;
    logic [1:0]  row;
    logic        word;
    logic [31:0] word0_buf;
    logic [47:0] rows_buf;

    logic [1:0]  off;
    logic        row_done;
    logic [63:0] row_words;
    logic [23:0] row_pixels;
    logic [31:0] next_row_addr;

    // A row starting at byte offset 2 or 3 straddles into the following word.
    assign off           = row_addr[1:0];
    assign row_done      = ~off[1] | word;
    assign row_words     = word ? {bus_rdata, word0_buf} : {32'h0, bus_rdata};
    assign row_pixels    = row_words[{off, 3'b000} +: 24];
    assign next_row_addr = row_addr + stride;

    // NOTE: every register here, including the data buffers, uses non-blocking
    // assignments and the asynchronous reset so a mid-transaction reset leaves no stale state.
    always_ff @(posedge clk or negedge internal_rst_n) begin
        if (!internal_rst_n) begin
            state          <= IDLE;
            row_addr       <= 32'h0;
            stride         <= 32'h0;
            row            <= 2'd0;
            word           <= 1'b0;
            word0_buf      <= 32'h0;
            rows_buf       <= 48'h0;
            mem_read_ack   <= 1'b0;
            mem_read_data  <= 72'h0;
            mem_write_ack  <= 1'b0;
            bus_req        <= 1'b0;
            bus_we         <= 1'b0;
            bus_addr       <= 32'h0;
            bus_wdata      <= 32'h0;
            bus_wstrb      <= 4'h0;
            busy           <= 1'b0;
            err_misaligned <= 1'b0;
        end else begin
            mem_read_ack  <= 1'b0;
            mem_write_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_write_req) begin
                        busy <= 1'b1;
                        if (mem_write_addr[0]) begin
                            err_misaligned <= 1'b1;
                            mem_write_ack  <= 1'b1;
                            state          <= WR_RESP;
                        end else begin
                            bus_req   <= 1'b1;
                            bus_we    <= 1'b1;
                            bus_addr  <= {mem_write_addr[31:2], 2'b00};
                            bus_wdata <= {2{mem_write_data}};
                            bus_wstrb <= mem_write_addr[1] ? 4'b1100 : 4'b0011;
                            state     <= WR_BUS;
                        end
                    end else if (mem_read_req) begin
                        busy      <= 1'b1;
                        row_addr  <= mem_read_addr;
                        stride    <= {16'h0, img_width};
                        row       <= 2'd0;
                        word      <= 1'b0;
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_wstrb <= 4'h0;
                        bus_addr  <= {mem_read_addr[31:2], 2'b00};
                        state     <= RD_FETCH;
                    end
                end
                RD_FETCH: begin
                    if (bus_ack) begin
                        if (!row_done) begin
                            word0_buf <= bus_rdata;
                            word      <= 1'b1;
                            bus_addr  <= bus_addr + 32'd4;
                        end else begin
                            word     <= 1'b0;
                            row_addr <= next_row_addr;
                            bus_addr <= {next_row_addr[31:2], 2'b00};
                            if (row == 2'd2) begin
                                mem_read_data <= {row_pixels, rows_buf};
                                mem_read_ack  <= 1'b1;
                                bus_req       <= 1'b0;
                                state         <= RD_RESP;
                            end else begin
                                if (row == 2'd0) rows_buf[23:0]  <= row_pixels;
                                else             rows_buf[47:24] <= row_pixels;
                                row <= row + 2'd1;
                            end
                        end
                    end
                end
                WR_BUS: begin
                    if (bus_ack) begin
                        bus_req       <= 1'b0;
                        bus_we        <= 1'b0;
                        mem_write_ack <= 1'b1;
                        state         <= WR_RESP;
                    end
                end
                RD_RESP, WR_RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_mem_responder.sv
// Self-checking bench for sobel_mem_responder: directed vector table, randomized
// reads/writes against a byte-level memory model, plus arbitration and reset sequences.
module tb_sobel_mem_responder;

    logic        clk = 1'b0;
    logic        internal_rst_n;
    logic [15:0] img_width;
    logic        mem_read_req;
    logic [31:0] mem_read_addr;
    logic        mem_read_ack;
    logic [71:0] mem_read_data;
    logic        mem_write_req;
    logic [31:0] mem_write_addr;
    logic [15:0] mem_write_data;
    logic        mem_write_ack;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        busy;
    logic        err_misaligned;

    always #5 clk = ~clk;

    sobel_mem_responder dut (
        .clk            (clk),
        .internal_rst_n (internal_rst_n),
        .img_width      (img_width),
        .mem_read_req   (mem_read_req),
        .mem_read_addr  (mem_read_addr),
        .mem_read_ack   (mem_read_ack),
        .mem_read_data  (mem_read_data),
        .mem_write_req  (mem_write_req),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_write_ack  (mem_write_ack),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_wstrb      (bus_wstrb),
        .bus_rdata      (bus_rdata),
        .bus_ack        (bus_ack),
        .busy           (busy),
        .err_misaligned (err_misaligned)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: plain byte-addressed contents, optionally scrambled.
    bit scramble = 1'b0;
    int max_wait = 0;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return scramble ? (a[7:0] ^ a[15:8] ^ 8'h5A) : a[7:0];
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = mem_byte(a + 32'(i));
        return w;
    endfunction

    // Bus slave with random wait states; logs every completed transfer.
    logic [31:0] log_addr[$];
    bit          log_we[$];
    logic [31:0] log_wdata[$];
    logic [3:0]  log_wstrb[$];
    int wait_cnt = 0, wait_target = 0, total_waits = 0;

    always @(negedge clk) begin
        if (bus_req && internal_rst_n) begin
            if (wait_cnt >= wait_target) begin
                bus_ack   = 1'b1;
                bus_rdata = mem_word(bus_addr);
                log_addr.push_back(bus_addr);
                log_we.push_back(bus_we);
                log_wdata.push_back(bus_wdata);
                log_wstrb.push_back(bus_wstrb);
                wait_cnt    = 0;
                wait_target = $urandom_range(max_wait, 0);
            end else begin
                bus_ack = 1'b0;
                wait_cnt++;
                total_waits++;
            end
        end else begin
            bus_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    int rd_ack_cnt = 0, wr_ack_cnt = 0;
    int exp_rd_acks = 0, exp_wr_acks = 0;
    always @(negedge clk) begin
        if (mem_read_ack)  rd_ack_cnt++;
        if (mem_write_ack) wr_ack_cnt++;
    end

    // Reference read: each pixel is simply the memory byte at row start + column.
    logic [31:0] exp_addrs[$];
    task automatic model_read(input logic [31:0] base, input logic [15:0] w, output logic [71:0] data);
        logic [31:0] a;
        exp_addrs.delete();
        data = '0;
        for (int r = 0; r < 3; r++) begin
            a = base + 32'(r) * {16'h0, w};
            for (int c = 0; c < 3; c++) data[8*(3*r+c) +: 8] = mem_byte(a + 32'(c));
            exp_addrs.push_back(a & ~32'h3);
            if ((a % 4) >= 2) exp_addrs.push_back((a & ~32'h3) + 32'd4);
        end
    endtask

    // One request, held until its ack; lat is the ack cycle counted from the sampling edge.
    task automatic do_txn(input bit is_wr, input logic [31:0] addr, input logic [15:0] width,
                          input logic [15:0] wdata, output int lat, output logic [71:0] rdata);
        @(negedge clk);
        log_addr.delete(); log_we.delete(); log_wdata.delete(); log_wstrb.delete();
        total_waits = 0;
        wait_target = $urandom_range(max_wait, 0);
        img_width = width;
        if (is_wr) begin
            mem_write_req = 1'b1; mem_write_addr = addr; mem_write_data = wdata;
        end else begin
            mem_read_req = 1'b1; mem_read_addr = addr;
        end
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (is_wr ? mem_write_ack : mem_read_ack) begin
                lat = n;
                break;
            end
        end
        mem_write_req = 1'b0;
        mem_read_req  = 1'b0;
        rdata = mem_read_data;
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [15:0] width;
        logic [15:0] wdata;
        int          exp_lat;
        logic [71:0] exp_rdata;
        int          exp_nbus;
        logic [31:0] exp_bus0;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          lat;
        logic [71:0] rdata, exp_data;
        logic [71:0] scen1;
        bit          is_wr;
        logic [31:0] addr;
        logic [15:0] width, wdata;
        int          wr_seen, rd_seen, wr_cyc, rd_cyc, acks_before;

        scen1 = 72'h42_41_40_22_21_20_02_01_00;
        vecs[0] = '{1'b0, 32'h100, 16'd32, 16'h0,    4, scen1,                          3, 32'h100, 4'h0, 32'h0};
        vecs[1] = '{1'b0, 32'h103, 16'd33, 16'h0,    5, 72'h47_46_45_26_25_24_05_04_03, 4, 32'h100, 4'h0, 32'h0};
        vecs[2] = '{1'b0, 32'h1FE, 16'd0,  16'h0,    7, 72'h00_FF_FE_00_FF_FE_00_FF_FE, 6, 32'h1FC, 4'h0, 32'h0};
        vecs[3] = '{1'b1, 32'h202, 16'd0,  16'hBEEF, 2, 72'h00_FF_FE_00_FF_FE_00_FF_FE, 1, 32'h200, 4'hC, 32'hBEEFBEEF};
        vecs[4] = '{1'b1, 32'h200, 16'd0,  16'h1234, 2, 72'h00_FF_FE_00_FF_FE_00_FF_FE, 1, 32'h200, 4'h3, 32'h12341234};
        vecs[5] = '{1'b1, 32'h201, 16'd0,  16'h5555, 1, 72'h00_FF_FE_00_FF_FE_00_FF_FE, 0, 32'h0,   4'h0, 32'h0};

        internal_rst_n = 1'b0;
        img_width = '0; mem_read_req = 0; mem_read_addr = '0;
        mem_write_req = 0; mem_write_addr = '0; mem_write_data = '0;
        bus_rdata = '0; bus_ack = 0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 72'({mem_read_ack, mem_write_ack, bus_req, bus_we, busy, err_misaligned}), 72'h0);
        check("reset_bus", 72'({bus_addr, bus_wdata, bus_wstrb}), 72'h0);
        check("reset_rdata", mem_read_data, 72'h0);
        internal_rst_n = 1'b1;

        // Directed table on a zero-wait bus with plain memory contents.
        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i].is_wr, vecs[i].addr, vecs[i].width, vecs[i].wdata, lat, rdata);
            if (vecs[i].is_wr) exp_wr_acks++; else exp_rd_acks++;
            check($sformatf("vec%0d_lat", i), 72'(lat), 72'(vecs[i].exp_lat));
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_nbus", i), 72'(log_addr.size()), 72'(vecs[i].exp_nbus));
            if (vecs[i].exp_nbus > 0 && log_addr.size() > 0) begin
                check($sformatf("vec%0d_bus0", i), 72'(log_addr[0]), 72'(vecs[i].exp_bus0));
                check($sformatf("vec%0d_we", i), 72'(log_we[0]), 72'(vecs[i].is_wr));
                if (vecs[i].is_wr) begin
                    check($sformatf("vec%0d_strb", i), 72'(log_wstrb[0]), 72'(vecs[i].exp_strb));
                    check($sformatf("vec%0d_wdata", i), 72'(log_wdata[0]), 72'(vecs[i].exp_wdata));
                end
            end
        end
        check("err_sticky", 72'(err_misaligned), 72'h1);

        // Randomized traffic with wait states against the model.
        scramble = 1'b1;
        max_wait = 2;
        for (int it = 0; it < 40; it++) begin
            is_wr = ($urandom_range(2, 0) == 0);
            addr  = $urandom;
            width = ($urandom_range(4, 0) == 0) ? 16'd0 : 16'($urandom_range(300, 1));
            wdata = 16'($urandom);
            do_txn(is_wr, addr, width, wdata, lat, rdata);
            if (is_wr) begin
                exp_wr_acks++;
                if (addr[0]) begin
                    check("rnd_mis_lat", 72'(lat), 72'd1);
                    check("rnd_mis_nbus", 72'(log_addr.size()), 72'd0);
                end else begin
                    check("rnd_wr_lat", 72'(lat), 72'(2 + total_waits));
                    check("rnd_wr_nbus", 72'(log_addr.size()), 72'd1);
                    if (log_addr.size() == 1)
                        check("rnd_wr_bus", 72'({log_we[0], log_addr[0], log_wdata[0], log_wstrb[0]}),
                              72'({1'b1, addr & ~32'h3, {2{wdata}}, addr[1] ? 4'b1100 : 4'b0011}));
                end
            end else begin
                exp_rd_acks++;
                model_read(addr, width, exp_data);
                check("rnd_rd_data", rdata, exp_data);
                check("rnd_rd_lat", 72'(lat), 72'(exp_addrs.size() + total_waits + 1));
                check("rnd_rd_nbus", 72'(log_addr.size()), 72'(exp_addrs.size()));
                for (int k = 0; k < log_addr.size() && k < exp_addrs.size(); k++)
                    check($sformatf("rnd_rd_addr%0d", k), 72'({log_we[k], log_addr[k]}), 72'({1'b0, exp_addrs[k]}));
            end
        end

        // Read and write raised together: write wins, then read, one ack each.
        scramble = 1'b0;
        max_wait = 0;
        @(negedge clk);
        wait_target = 0;
        img_width = 16'd32;
        mem_write_req = 1'b1; mem_write_addr = 32'h204; mem_write_data = 16'hCAFE;
        mem_read_req  = 1'b1; mem_read_addr  = 32'h100;
        wr_seen = 0; rd_seen = 0; wr_cyc = -1; rd_cyc = -1; rdata = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_write_ack) begin wr_seen++; wr_cyc = n; mem_write_req = 1'b0; end
            if (mem_read_ack)  begin rd_seen++; rd_cyc = n; rdata = mem_read_data; mem_read_req = 1'b0; end
        end
        mem_write_req = 1'b0; mem_read_req = 1'b0;
        exp_wr_acks++; exp_rd_acks++;
        check("both_wr_once", 72'(wr_seen), 72'd1);
        check("both_rd_once", 72'(rd_seen), 72'd1);
        check("both_wr_cycle", 72'(wr_cyc), 72'd2);
        check("both_rd_cycle", 72'(rd_cyc), 72'd7);
        check("both_rd_data", rdata, scen1);

        // Reset after the second bus ack of a read: everything clears, no ack.
        @(negedge clk);
        log_addr.delete(); log_we.delete(); log_wdata.delete(); log_wstrb.delete();
        wait_target = 0;
        img_width = 16'd32;
        mem_read_req = 1'b1; mem_read_addr = 32'h100;
        for (int n = 0; n < 50 && log_addr.size() < 2; n++) @(negedge clk);
        check("rst_two_acks", 72'(log_addr.size()), 72'd2);
        @(posedge clk);
        acks_before = rd_ack_cnt;
        #2 internal_rst_n = 1'b0;
        #1;
        check("rst_ctrl", 72'({mem_read_ack, mem_write_ack, bus_req, bus_we, busy, err_misaligned}), 72'h0);
        check("rst_bus", 72'({bus_addr, bus_wdata, bus_wstrb}), 72'h0);
        check("rst_rdata", mem_read_data, 72'h0);
        mem_read_req = 1'b0;
        repeat (4) @(negedge clk);
        internal_rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_no_ack", 72'(rd_ack_cnt - acks_before), 72'd0);
        do_txn(1'b0, 32'h100, 16'd32, 16'h0, lat, rdata);
        exp_rd_acks++;
        check("post_rst_data", rdata, scen1);
        check("post_rst_lat", 72'(lat), 72'd4);

        repeat (3) @(negedge clk);
        check("total_rd_acks", 72'(rd_ack_cnt), 72'(exp_rd_acks));
        check("total_wr_acks", 72'(wr_ack_cnt), 72'(exp_wr_acks));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sobel_mem_responder.md
# sobel_mem_responder

Memory-side responder for the Sobel accelerator's request interface. It accepts 3x3-window read requests (72-bit) and 16-bit result write requests from the accelerator and serves them over a 32-bit word-addressed system bus. Each window read is split into per-row word fetches, with row-straddle handling. Each result write becomes one byte-strobed word write. It sits between the accelerator's memory port and the SoC memory bus bridge.

## Interface
- No parameters.
- clk  in  1  clock
- internal_rst_n  in  1  reset, asynchronous, active-low
- img_width  in  16  row stride in bytes; sampled when a read is accepted
- mem_read_req  in  1  window read request, level, held until ack
- mem_read_addr  in  32  byte address of the window's top-left pixel
- mem_read_ack  out  1  one-cycle pulse; mem_read_data valid in that cycle
- mem_read_data  out  72  pixel (r,c) at bits [8k+7:8k], k=3r+c
- mem_write_req  in  1  result write request, level, held until ack
- mem_write_addr  in  32  byte address; must be halfword aligned
- mem_write_data  in  16  result value
- mem_write_ack  out  1  one-cycle pulse
- bus_req  out  1  system bus request, held until bus_ack
- bus_we  out  1  1 = write
- bus_addr  out  32  word-aligned address ([1:0]=0)
- bus_wdata  out  32  write data
- bus_wstrb  out  4  byte lane enables, little-endian
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  one-cycle completion; may arrive in the first cycle bus_req is high
- busy  out  1  high whenever state != IDLE
- err_misaligned  out  1  sticky; set by an odd write address; cleared only by reset

## Operation
- States: IDLE, RD_FETCH, RD_RESP, WR_BUS, WR_RESP.
- IDLE arbitration: mem_write_req has priority over mem_read_req. The other request stays pending and is served on the next return to IDLE.
- Read accept (IDLE):
  - latch base=mem_read_addr and stride=img_width; row=0, word=0; go to RD_FETCH.
- RD_FETCH:
  - row address A = base + row*stride, 32-bit modulo; off = A[1:0].
  - word0 = {A[31:2],2'b00}; word1 = word0+4, fetched only if off>=2.
  - On each bus_ack, store bus_rdata in a row buffer.
  - Once the row's words are in, pixel c = byte (off+c) of {word1,word0}. Write it to mem_read_data byte 3*row+c, then advance row.
  - After row 2 completes, go to RD_RESP.
- RD_RESP: mem_read_ack=1 for one cycle; return to IDLE.
- Write accept (IDLE), addr[0]=0:
  - bus_addr={addr[31:2],2'b00}, bus_wdata={2{data}}, bus_wstrb = addr[1] ? 4'b1100 : 4'b0011; go to WR_BUS.
- Write accept (IDLE), addr[0]=1:
  - no bus access; set err_misaligned; go to WR_RESP.
- WR_BUS: hold request until bus_ack, then go to WR_RESP.
- WR_RESP: mem_write_ack=1 for one cycle; return to IDLE.
- Requests are ignored outside IDLE. A req still high in the cycle after ack is a new transaction.
- img_width=0: all three rows read the same address (legal).

## Timing
- Reset values: all outputs 0, mem_read_data 0, state IDLE.
- Reset is asynchronous at any point. bus_req drops immediately and the in-flight transaction is abandoned with no ack.
- Bus outputs are registered: bus_req rises the cycle after acceptance.
- Read latency, zero-wait bus: request sampled at cycle 0, N bus words (3..6), mem_read_ack at cycle N+1. Each bus wait state adds one cycle.
- Write latency, zero-wait bus: mem_write_ack at cycle 2. Misaligned write: ack at cycle 1.
- mem_read_data holds its value until the next read completes.
- Between bus transactions within one read, bus_req may stay high. A new bus_addr takes effect the cycle after bus_ack.

## Test plan
- Aligned read: memory byte = addr[7:0], addr 0x100, width 32, zero-wait.
  - Expect 3 bus reads (0x100, 0x120, 0x140).
  - Data bytes k0..k8 = 00,01,02,20,21,22,40,41,42.
  - mem_read_ack at cycle 4.
- Straddle read: addr 0x103, width 33.
  - Rows 0x103, 0x124, 0x145; 4 bus reads (0x100, 0x104, 0x124, 0x144).
  - Bytes 03,04,05,24,25,26,45,46,47; ack at cycle 5.
- Write: addr 0x202, data 0xBEEF.
  - bus_addr 0x200, wstrb 1100, wdata 0xBEEFBEEF; mem_write_ack at cycle 2.
  - Second write at 0x200: wstrb 0011.
- Misaligned write at 0x201:
  - no bus_req; mem_write_ack at cycle 1; err_misaligned=1 until reset.
- Read and write requests raised in the same cycle:
  - write completes and acks first, then the read; each acked exactly once.
- Reset asserted after the 2nd bus_ack of a read:
  - all outputs 0 immediately; no mem_read_ack.
  - After release, a new read at 0x100 returns the scenario-1 data.
